// File: rtl/fetch_stall_ctrl.sv
// IF/ID control: load-use hazard stall, fixed-length multi-cycle EX freeze, branch flush,
// and a saturating stall-cycle counter. Outputs are combinational from state and inputs.
module fetch_stall_ctrl #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       InstructionDecode,
   input  logic              IDEX_MemRead,
   input  logic [4:0]        IDEX_Rt,
   input  logic              BranchTaken,
   input  logic              MultiCycleStart,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              IFIDFlush,
   output logic              ControlBubble,
   output logic              Busy,
   output logic [PERF_W-1:0] StallCycles
);

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [5:0] op;
   logic [4:0] rs, rt;
   logic       uses_rt;
   logic       load_use;
   logic       unused_bits;

   assign op          = InstructionDecode[31:26];
   assign rs          = InstructionDecode[25:21];
   assign rt          = InstructionDecode[20:16];
   assign unused_bits = ^InstructionDecode[15:0];

   // R-type, beq/bne and stores read rt as a source; everything else only reads rs.
   assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
                    (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);

   assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == rs) || (uses_rt && (IDEX_Rt == rt)));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (MultiCycleStart) begin
               state_nxt = MC_WAIT;
               cnt_nxt   = CNT_W'(MC_LATENCY - 1);
            end
         end
         MC_WAIT: begin
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Flush is only ever raised with IFIDWrite low, since the register favours write over clear.
   always_comb begin
      PCWrite       = 1'b1;
      IFIDWrite     = 1'b1;
      IFIDFlush     = 1'b0;
      ControlBubble = 1'b0;
      Busy          = 1'b0;
      if (Reset) begin
         PCWrite       = 1'b0;
         IFIDWrite     = 1'b0;
         IFIDFlush     = 1'b1;
         ControlBubble = 1'b1;
      end else if (state == MC_WAIT) begin
         PCWrite       = 1'b0;
         IFIDWrite     = 1'b0;
         ControlBubble = 1'b1;
         Busy          = 1'b1;
      end else if (load_use) begin
         PCWrite       = 1'b0;
         IFIDWrite     = 1'b0;
         ControlBubble = 1'b1;
      end else if (BranchTaken) begin
         IFIDWrite     = 1'b0;
         IFIDFlush     = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         StallCycles <= '0;
      else if (!PCWrite && (StallCycles != {PERF_W{1'b1}}))
         StallCycles <= StallCycles + 1'b1;
   end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed then random stimulus against a cycle-level reference model; a second narrow-counter
// instance shares the stimulus so counter saturation is reached quickly.
module tb_fetch_stall_ctrl;

   localparam int LAT = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] InstructionDecode;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_Rt;
   logic        BranchTaken;
   logic        MultiCycleStart;

   logic        PCWrite, IFIDWrite, IFIDFlush, ControlBubble, Busy;
   logic [15:0] StallCycles;
   logic        n_PCWrite, n_IFIDWrite, n_IFIDFlush, n_ControlBubble, n_Busy;
   logic [2:0]  n_StallCycles;

   int total = 0;
   int bad   = 0;

   int m_wait   = 0;
   int m_stalls = 0;
   bit m_known  = 1'b0;

   localparam logic [31:0] ADD_T2_T0_T1 = 32'h0109_5020;
   localparam logic [31:0] LW_T0_T1     = 32'h8D28_0000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   always #5 Clk = ~Clk;

   fetch_stall_ctrl #(.MC_LATENCY(LAT), .CNT_W(4), .PERF_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .InstructionDecode(InstructionDecode),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
      .MultiCycleStart(MultiCycleStart), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .IFIDFlush(IFIDFlush), .ControlBubble(ControlBubble), .Busy(Busy),
      .StallCycles(StallCycles)
   );

   fetch_stall_ctrl #(.MC_LATENCY(LAT), .CNT_W(4), .PERF_W(3)) dut_narrow (
      .Clk(Clk), .Reset(Reset), .InstructionDecode(InstructionDecode),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
      .MultiCycleStart(MultiCycleStart), .PCWrite(n_PCWrite), .IFIDWrite(n_IFIDWrite),
      .IFIDFlush(n_IFIDFlush), .ControlBubble(n_ControlBubble), .Busy(n_Busy),
      .StallCycles(n_StallCycles)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads_rt(input logic [5:0] opc);
      return opc inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
   endfunction

   // One clock cycle: apply inputs, check combinational outputs, then advance the model.
   task automatic step(input bit rst, input logic [31:0] instr, input bit mr,
                       input logic [4:0] rt, input bit br, input bit mcs);
      bit hazard;
      bit e_pc, e_ifw, e_fl, e_cb, e_busy;
      Reset             = rst;
      InstructionDecode = instr;
      IDEX_MemRead      = mr;
      IDEX_Rt           = rt;
      BranchTaken       = br;
      MultiCycleStart   = mcs;
      #3;
      hazard = mr && rt != 0 &&
               (rt == instr[25:21] || (reads_rt(instr[31:26]) && rt == instr[20:16]));
      if (rst)             {e_pc, e_ifw, e_fl, e_cb, e_busy} = 5'b00110;
      else if (m_wait > 0) {e_pc, e_ifw, e_fl, e_cb, e_busy} = 5'b00011;
      else if (hazard)     {e_pc, e_ifw, e_fl, e_cb, e_busy} = 5'b00010;
      else if (br)         {e_pc, e_ifw, e_fl, e_cb, e_busy} = 5'b10100;
      else                 {e_pc, e_ifw, e_fl, e_cb, e_busy} = 5'b11000;
      check("PCWrite",       {31'd0, PCWrite},       {31'd0, e_pc});
      check("IFIDWrite",     {31'd0, IFIDWrite},     {31'd0, e_ifw});
      check("IFIDFlush",     {31'd0, IFIDFlush},     {31'd0, e_fl});
      check("ControlBubble", {31'd0, ControlBubble}, {31'd0, e_cb});
      check("Busy",          {31'd0, Busy},          {31'd0, e_busy});
      if (m_known) begin
         check("StallCycles",   {16'd0, StallCycles},  (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
         check("StallCycles_3b", {29'd0, n_StallCycles}, (m_stalls > 7) ? 32'd7 : 32'(m_stalls));
      end
      @(posedge Clk);
      if (rst) begin
         m_wait   = 0;
         m_stalls = 0;
         m_known  = 1'b1;
      end else begin
         if (!e_pc) m_stalls++;
         if (m_wait > 0) m_wait--;
         else if (mcs)   m_wait = LAT;
      end
      #1;
   endtask

   initial begin
      logic [5:0]  ops [8];
      logic [4:0]  rts [4];
      logic [31:0] rnd;
      ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h28, 6'h3F, 6'h11};
      rts = '{5'd0, 5'd8, 5'd9, 5'd31};

      step(1, NOP, 0, 0, 0, 0);
      step(1, NOP, 0, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 0);

      // load-use on rs, then suppressed by $zero and by a non-rt-reading load
      step(0, ADD_T2_T0_T1, 1, 8, 0, 0);
      step(0, NOP, 0, 0, 0, 0);
      step(0, ADD_T2_T0_T1, 1, 0, 0, 0);
      step(0, LW_T0_T1, 1, 8, 0, 0);

      // multi-cycle op with a second pulse during the wait
      step(0, NOP, 0, 0, 0, 1);
      step(0, NOP, 0, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 1);
      step(0, NOP, 0, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 0);

      // branch flush, then branch masked by load-use
      step(0, NOP, 0, 0, 1, 0);
      step(0, ADD_T2_T0_T1, 1, 8, 1, 0);

      // load-use coinciding with multi-cycle start
      step(0, ADD_T2_T0_T1, 1, 8, 0, 1);
      for (int i = 0; i < LAT + 1; i++) step(0, NOP, 0, 0, 0, 0);

      // reset on the second wait cycle aborts the wait
      step(0, NOP, 0, 0, 0, 1);
      step(0, NOP, 0, 0, 0, 0);
      step(1, NOP, 0, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 0);

      // drive the narrow counter into saturation and hold it there
      for (int i = 0; i < 10; i++) step(0, ADD_T2_T0_T1, 1, 9, 0, 0);
      step(0, NOP, 0, 0, 0, 0);

      for (int i = 0; i < 800; i++) begin
         rnd = $urandom;
         step($urandom_range(0, 39) == 0,
              {ops[$urandom_range(0, 7)], rnd[25:0]},
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? 5'($urandom) : rts[$urandom_range(0, 3)],
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
